icache_fetch: RTL and testbench

Instruction-fetch stage with an integrated direct-mapped instruction cache. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and looks up the current PC in a small cache. It presents `instruction`, `pc` (PC+4) and `hit` to IF/ID, and services misses through a single-outstanding request/ready handshake to instruction memory.

---
 rtl/icache_fetch_if.sv | 59 +++++
 rtl/icache_fetch.sv | 157 +++++++++++++++
 tb/tb_icache_fetch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fetch_if
//  Description : Bundle of the fetch-stage signals. It groups the pipeline
//                side (hazard/redirect controls in, presented instruction
//                out) and the single-outstanding instruction-memory read
//                channel.
//  Modports    : slave  - the fetch stage (icache_fetch)
//                master - the surrounding pipeline / memory model
//  Signals     : stall, pcS, branchT        pipeline -> fetch
//                pc, instruction, hit       fetch    -> IF/ID
//                mem_req, mem_addr          fetch    -> memory
//                mem_ready, mem_rdata       memory   -> fetch
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_fetch_if;
    // Pipeline control
    logic        stall;
    logic        pcS;
    logic [31:0] branchT;

    // Presented fetch result
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        hit;

    // Instruction-memory read channel
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  stall,
        input  pcS,
        input  branchT,
        input  mem_ready,
        input  mem_rdata,
        output pc,
        output instruction,
        output hit,
        output mem_req,
        output mem_addr
    );

    modport master (
        output stall,
        output pcS,
        output branchT,
        output mem_ready,
        output mem_rdata,
        input  pc,
        input  instruction,
        input  hit,
        input  mem_req,
        input  mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fetch
//  Description : Instruction-fetch stage with an integrated direct-mapped
//                instruction cache (one 32-bit word per line). Owns the PC,
//                looks it up combinationally, presents the instruction to
//                IF/ID and refills misses through a single-outstanding
//                request/ready handshake.
//  Parameters  : LINES    - number of cache lines (power of two, >= 2)
//                RESET_PC - PC value loaded by reset
//  Ports       : clock    - rising-edge clock
//                reset    - asynchronous active-high reset
//                bus      - icache_fetch_if.slave
//                           in : stall, pcS, branchT, mem_ready, mem_rdata
//                           out: pc (PC+4), instruction, hit,
//                                mem_req, mem_addr
//  Revision    : 1.0  initial release
// ============================================================================
module icache_fetch #(
    parameter int          LINES    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clock,
    input  logic           reset,
    icache_fetch_if.slave  bus
);

    // ------------------------------------------------------------------
    // Address split: [1:0] byte offset (ignored), then index, then tag.
    // ------------------------------------------------------------------
    localparam int c_IDX_W = $clog2(LINES);
    localparam int c_TAG_W = 30 - c_IDX_W;

    localparam logic [0:0] c_LOOKUP   = 1'b0;
    localparam logic [0:0] c_WAIT_MEM = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         state_q,     state_d;
    logic [31:0]        pc_q,        pc_d;
    logic [31:0]        miss_addr_q, miss_addr_d;

    // Valid bits are reset; tag and data arrays are plain storage.
    logic [LINES-1:0]   valid_q;
    logic [c_TAG_W-1:0] tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    // ------------------------------------------------------------------
    // Combinational lookup from the PC register
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_lookup_hit;
    logic               w_in_lookup;
    logic               w_hit;

    logic               w_fill;
    logic [c_IDX_W-1:0] w_fill_idx;
    logic [c_TAG_W-1:0] w_fill_tag;

    assign w_idx        = pc_q[c_IDX_W+1:2];
    assign w_tag        = pc_q[31:c_IDX_W+2];
    assign w_lookup_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_in_lookup  = (state_q == c_LOOKUP);
    // The line may already be valid while a fill is pending, so the
    // presented hit is gated by the state as well.
    assign w_hit        = w_in_lookup && w_lookup_hit;

    // mem_ready is only meaningful while a request is outstanding; a late
    // response arriving in LOOKUP (e.g. after a reset) must not write.
    assign w_fill       = (state_q == c_WAIT_MEM) && bus.mem_ready;
    assign w_fill_idx   = miss_addr_q[c_IDX_W+1:2];
    assign w_fill_tag   = miss_addr_q[31:c_IDX_W+2];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;

        case (state_q)
            c_LOOKUP: begin
                if (bus.pcS) begin
                    // Redirect wins over stall and over a miss; no request
                    // is issued for the abandoned PC.
                    pc_d = bus.branchT;
                end else if (w_lookup_hit) begin
                    if (!bus.stall) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    miss_addr_d = {pc_q[31:2], 2'b00};
                    state_d     = c_WAIT_MEM;
                end
            end

            c_WAIT_MEM: begin
                // stall is ignored here. A redirect is taken immediately;
                // the outstanding fill still lands at miss_addr so memory
                // and cache stay consistent.
                if (bus.pcS) begin
                    pc_d = bus.branchT;
                end
                if (bus.mem_ready) begin
                    state_d = c_LOOKUP;
                end
            end

            default: begin
                state_d = c_LOOKUP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= c_LOOKUP;
            pc_q        <= RESET_PC;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
            if (w_fill) begin
                valid_q[w_fill_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag / data arrays: a fill overwrites its line unconditionally.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_fill) begin
            tag_q[w_fill_idx]  <= w_fill_tag;
            data_q[w_fill_idx] <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc          = pc_q + 32'd4;
    assign bus.hit         = w_hit;
    assign bus.instruction = w_hit ? data_q[w_idx] : 32'h0000_0000;
    assign bus.mem_req     = (state_q == c_WAIT_MEM);
    assign bus.mem_addr    = miss_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_fetch
//  Description : Self-checking bench for icache_fetch. Directed scenarios for
//                reset, cold miss, sequential hits, eviction, redirect during
//                a miss, stall priority, PC wrap and reset mid-miss, followed
//                by a randomized run checked against a behavioural model
//                (cache as a table of line addresses, memory as a function).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_fetch;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    icache_fetch_if bus ();

    icache_fetch #(
        .LINES    (16),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Backing memory contents for the randomized run.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.pcS       = 1'b0;
        bus.branchT   = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.pcS     = 1'b1;
        bus.branchT = t;
        step();
        bus.pcS     = 1'b0;
    endtask

    // Waits (bounded) for a request, then answers it in its ready_after-th
    // request cycle. Returns at the first cycle after the response.
    task automatic serve_miss(input logic [31:0] data, input int ready_after,
                              output bit ok, output logic [31:0] addr,
                              output int req_cycles);
        ok         = 1'b1;
        addr       = 32'h0;
        req_cycles = 0;
        for (int w = 0; w < 8 && !bus.mem_req; w++) step();
        if (!bus.mem_req) begin
            ok = 1'b0;
            return;
        end
        addr = bus.mem_addr;
        for (int c = 0; c < ready_after; c++) begin
            if (!bus.mem_req || bus.mem_addr !== addr) begin
                ok = 1'b0;
                return;
            end
            req_cycles++;
            if (c == ready_after - 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = data;
                step();
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end else begin
                step();
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        #2 reset = 1'b1;
        #2;
        n_checks++;
        if ({bus.pc, bus.hit, bus.instruction, bus.mem_req, bus.mem_addr} !==
            {32'h4, 1'b0, 32'h0, 1'b0, 32'h0})
            $display("FAIL reset_outputs: pc=%h hit=%b instr=%h req=%b addr=%h expected pc=4 others 0",
                     bus.pc, bus.hit, bus.instruction, bus.mem_req, bus.mem_addr);
        else n_pass++;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        bit ok; logic [31:0] a; int rc;
        n_checks++;
        if ({bus.hit, bus.mem_req} !== 2'b00)
            $display("FAIL cold_first_cycle: hit=%b req=%b expected 0 0", bus.hit, bus.mem_req);
        else n_pass++;
        serve_miss(32'h2008_0005, 2, ok, a, rc);
        n_checks++;
        if (!ok || a !== 32'h0 || rc != 2)
            $display("FAIL cold_request: ok=%0d addr=%h req_cycles=%0d expected 1 0 2", ok, a, rc);
        else n_pass++;
        n_checks++;
        if ({bus.hit, bus.instruction, bus.pc, bus.mem_req} !== {1'b1, 32'h2008_0005, 32'h4, 1'b0})
            $display("FAIL cold_hit_after: hit=%b instr=%h pc=%h req=%b expected 1 20080005 4 0",
                     bus.hit, bus.instruction, bus.pc, bus.mem_req);
        else n_pass++;
    endtask

    task automatic test_sequential();
        bit ok; logic [31:0] a; int rc;
        logic [31:0] exp_i;
        for (int k = 1; k <= 3; k++) begin
            step();
            serve_miss(32'hA000_0000 | (k * 4), 1 + int'($urandom % 3), ok, a, rc);
            n_checks++;
            if (!ok || a !== 32'(k * 4))
                $display("FAIL seq_preload: ok=%0d addr=%h expected %h", ok, a, 32'(k * 4));
            else n_pass++;
        end
        redirect(32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_i = (i == 0) ? 32'h2008_0005 : (32'hA000_0000 | 32'(i * 4));
            n_checks++;
            if ({bus.hit, bus.pc, bus.instruction, bus.mem_req} !== {1'b1, 32'((i + 1) * 4), exp_i, 1'b0})
                $display("FAIL seq_hit%0d: hit=%b pc=%h instr=%h req=%b expected 1 %h %h 0",
                         i, bus.hit, bus.pc, bus.instruction, bus.mem_req, 32'((i + 1) * 4), exp_i);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_conflict();
        bit ok; logic [31:0] a; int rc;
        redirect(32'h40);
        serve_miss(32'hB000_0040, 2, ok, a, rc);
        n_checks++;
        if (!ok || a !== 32'h40) $display("FAIL conflict_fill_b: ok=%0d addr=%h expected 40", ok, a);
        else n_pass++;
        bus.stall = 1'b1;
        step();
        bus.stall = 1'b0;
        n_checks++;
        if ({bus.hit, bus.instruction} !== {1'b1, 32'hB000_0040})
            $display("FAIL conflict_b_valid: hit=%b instr=%h expected 1 b0000040", bus.hit, bus.instruction);
        else n_pass++;
        redirect(32'h0);
        n_checks++;
        if (bus.hit !== 1'b0) $display("FAIL conflict_a_evicted: hit=%b expected 0", bus.hit);
        else n_pass++;
        serve_miss(32'h2008_0005, 1, ok, a, rc);
        n_checks++;
        if (!ok || a !== 32'h0 || bus.instruction !== 32'h2008_0005)
            $display("FAIL conflict_refill_a: ok=%0d addr=%h instr=%h expected 1 0 20080005", ok, a, bus.instruction);
        else n_pass++;
        redirect(32'h40);
        n_checks++;
        if (bus.hit !== 1'b0) $display("FAIL conflict_b_evicted: hit=%b expected 0", bus.hit);
        else n_pass++;
        serve_miss(32'hB000_0040, 1, ok, a, rc);
    endtask

    task automatic test_redirect_miss();
        bit ok; logic [31:0] a; int rc;
        do_reset();
        redirect(32'h8);
        step();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8})
            $display("FAIL redir_req: req=%b addr=%h expected 1 8", bus.mem_req, bus.mem_addr);
        else n_pass++;
        bus.pcS = 1'b1; bus.branchT = 32'h100;
        step();
        bus.pcS = 1'b0;
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, bus.hit} !== {1'b1, 32'h8, 1'b0})
            $display("FAIL redir_req_held: req=%b addr=%h hit=%b expected 1 8 0", bus.mem_req, bus.mem_addr, bus.hit);
        else n_pass++;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hD000_0008;
        step();
        bus.mem_ready = 1'b0;
        n_checks++;
        if ({bus.hit, bus.mem_req, bus.pc} !== {1'b0, 1'b0, 32'h104})
            $display("FAIL redir_new_pc_miss: hit=%b req=%b pc=%h expected 0 0 104", bus.hit, bus.mem_req, bus.pc);
        else n_pass++;
        serve_miss(32'hD000_0100, 2, ok, a, rc);
        n_checks++;
        if (!ok || a !== 32'h100 || bus.instruction !== 32'hD000_0100)
            $display("FAIL redir_second_fill: ok=%0d addr=%h instr=%h expected 1 100 d0000100", ok, a, bus.instruction);
        else n_pass++;
        redirect(32'h8);
        n_checks++;
        if ({bus.hit, bus.instruction, bus.pc} !== {1'b1, 32'hD000_0008, 32'hC})
            $display("FAIL redir_line2_written: hit=%b instr=%h pc=%h expected 1 d0000008 c", bus.hit, bus.instruction, bus.pc);
        else n_pass++;
    endtask

    task automatic test_stall_priority();
        bit ok; logic [31:0] a; int rc;
        redirect(32'h10);
        serve_miss(32'hC000_0010, 1, ok, a, rc);
        n_checks++;
        if (!ok || a !== 32'h10) $display("FAIL stall_setup: ok=%0d addr=%h expected 10", ok, a);
        else n_pass++;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({bus.pc, bus.hit, bus.instruction, bus.mem_req} !== {32'h14, 1'b1, 32'hC000_0010, 1'b0})
                $display("FAIL stall_hold%0d: pc=%h hit=%b instr=%h req=%b expected 14 1 c0000010 0",
                         i, bus.pc, bus.hit, bus.instruction, bus.mem_req);
            else n_pass++;
        end
        bus.pcS = 1'b1; bus.branchT = 32'h40;
        step();
        bus.pcS = 1'b0;
        n_checks++;
        if (bus.pc !== 32'h44) $display("FAIL stall_pcs_wins: pc=%h expected 44", bus.pc);
        else n_pass++;
        // stall still high: must not block the miss or the fill
        step();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40})
            $display("FAIL stall_in_wait_req: req=%b addr=%h expected 1 40", bus.mem_req, bus.mem_addr);
        else n_pass++;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hC000_0040;
        step();
        bus.mem_ready = 1'b0;
        n_checks++;
        if ({bus.hit, bus.instruction} !== {1'b1, 32'hC000_0040})
            $display("FAIL stall_in_wait_fill: hit=%b instr=%h expected 1 c0000040", bus.hit, bus.instruction);
        else n_pass++;
        bus.stall = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok; logic [31:0] a; int rc;
        redirect(32'hFFFF_FFFC);
        serve_miss(32'hEEEE_0001, 1, ok, a, rc);
        n_checks++;
        if (!ok || a !== 32'hFFFF_FFFC || bus.hit !== 1'b1 || bus.pc !== 32'h0)
            $display("FAIL wrap_top: ok=%0d addr=%h hit=%b pc=%h expected 1 fffffffc 1 0", ok, a, bus.hit, bus.pc);
        else n_pass++;
        step();
        n_checks++;
        if (bus.pc !== 32'h4) $display("FAIL wrap_to_zero: pc=%h expected 4", bus.pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_miss();
        bit ok; logic [31:0] a; int rc;
        redirect(32'h20);
        step();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h20})
            $display("FAIL rmm_req: req=%b addr=%h expected 1 20", bus.mem_req, bus.mem_addr);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, bus.pc, bus.hit} !== {1'b0, 32'h0, 32'h4, 1'b0})
            $display("FAIL rmm_async: req=%b addr=%h pc=%h hit=%b expected 0 0 4 0", bus.mem_req, bus.mem_addr, bus.pc, bus.hit);
        else n_pass++;
        @(posedge clock);
        #1 reset = 1'b0;
        n_checks++;
        if ({bus.hit, bus.mem_req} !== 2'b00)
            $display("FAIL rmm_first_lookup: hit=%b req=%b expected 0 0", bus.hit, bus.mem_req);
        else n_pass++;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ready = 1'b0;
        n_checks++;
        if ({bus.hit, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL rmm_late_ready_ignored: hit=%b req=%b addr=%h expected 0 1 0", bus.hit, bus.mem_req, bus.mem_addr);
        else n_pass++;
        serve_miss(32'h1111_0000, 1, ok, a, rc);
        redirect(32'h20);
        n_checks++;
        if (bus.hit !== 1'b0) $display("FAIL rmm_no_line_written: hit=%b expected 0", bus.hit);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Randomized run against a behavioural model: each line remembers the
    // word address it holds, memory contents come from mem_word().
    // ------------------------------------------------------------------
    task automatic test_random();
        bit          m_valid [16];
        logic [31:0] m_line  [16];
        logic [31:0] m_pc, m_miss, bt;
        bit          m_wait, exp_hit, s_pcs, s_stall, s_rdy;
        logic [31:0] exp_instr;
        int          li, mi;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = 32'h0;
        end
        m_pc = 32'h0; m_miss = 32'h0; m_wait = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            li        = int'((m_pc >> 2) % 16);
            exp_hit   = !m_wait && m_valid[li] && (m_line[li] == (m_pc >> 2));
            exp_instr = exp_hit ? mem_word(m_pc) : 32'h0;
            n_checks++;
            if ({bus.pc, bus.hit, bus.instruction, bus.mem_req} !== {m_pc + 32'd4, exp_hit, exp_instr, m_wait} ||
                (m_wait && bus.mem_addr !== m_miss))
                $display("FAIL random_cycle%0d: pc=%h hit=%b instr=%h req=%b addr=%h expected %h %b %h %b %h",
                         cyc, bus.pc, bus.hit, bus.instruction, bus.mem_req, bus.mem_addr,
                         m_pc + 32'd4, exp_hit, exp_instr, m_wait, m_miss);
            else n_pass++;

            s_pcs   = ($urandom % 8) == 0;
            s_stall = ($urandom % 4) == 0;
            s_rdy   = m_wait ? ($urandom % 2) == 0 : ($urandom % 4) == 0;
            bt      = 32'(($urandom % 4) << 6) | 32'(($urandom % 16) << 2);
            if (($urandom % 16) == 0) bt = bt | 32'hFFFF_FF00;
            bus.pcS       = s_pcs;
            bus.branchT   = bt;
            bus.stall     = s_stall;
            bus.mem_ready = s_rdy;
            bus.mem_rdata = m_wait ? mem_word(m_miss) : $urandom;

            if (!m_wait) begin
                if (s_pcs)          m_pc = bt;
                else if (exp_hit)   m_pc = s_stall ? m_pc : m_pc + 32'd4;
                else begin
                    m_miss = m_pc & ~32'h3;
                    m_wait = 1'b1;
                end
            end else begin
                if (s_rdy) begin
                    mi          = int'((m_miss >> 2) % 16);
                    m_valid[mi] = 1'b1;
                    m_line[mi]  = m_miss >> 2;
                    m_wait      = 1'b0;
                end
                if (s_pcs) m_pc = bt;
            end
            step();
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_cold_miss();
        test_sequential();
        test_conflict();
        test_redirect_miss();
        test_stall_priority();
        test_wrap();
        test_reset_mid_miss();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
